// File: rtl/qos_wr_arbiter.sv
// -----------------------------------------------------------------------------
// qos_wr_arbiter
// Write-side arbiter in front of the QoS FIFO wrapper. At most one of NREQ
// masters is accepted per cycle. Age-promoted requesters win over
// high-bandwidth requesters (QoS[3]=1), which win over normal requesters.
// Inside each tier the choice is round-robin. A lock bit lets a master keep
// the port for a multi-beat burst.
//
// Ports
//   iWrClk, iWrResetn : write-side clock and asynchronous active-low reset
//   iReqValid/Data/QoS/Lock : per-requester request bundle (requester i at
//                       slice i of each flattened vector)
//   oReqReady         : one-hot combinational accept
//   iFull             : wrapper full flag; no beat is accepted while it is set
//   oWr/oWrData/oQoS  : registered write beat towards the wrapper
//   oGrant            : registered one-hot index of the last accepted requester
//   oStarve           : one-cycle pulse when the accepted beat was age-promoted
// -----------------------------------------------------------------------------
module qos_wr_arbiter #(
   parameter int NREQ    = 4,
   parameter int DSIZE   = 32,
   parameter int AGE_MAX = 15
) (
   input  logic                  iWrClk,
   input  logic                  iWrResetn,
   input  logic [NREQ-1:0]       iReqValid,
   input  logic [NREQ*DSIZE-1:0] iReqData,
   input  logic [NREQ*4-1:0]     iReqQoS,
   input  logic [NREQ-1:0]       iReqLock,
   output logic [NREQ-1:0]       oReqReady,
   input  logic                  iFull,
   output logic                  oWr,
   output logic [DSIZE-1:0]      oWrData,
   output logic [3:0]            oQoS,
   output logic [NREQ-1:0]       oGrant,
   output logic                  oStarve
);

   localparam int         IW      = $clog2(NREQ);
   localparam logic [7:0] AGE_LIM = 8'(AGE_MAX);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t          r_state, w_stateNext;
   logic [IW-1:0]   r_owner, w_ownerNext;
   logic [7:0]      r_lockIdle, w_lockIdleNext;
   logic [IW-1:0]   r_rrHi, r_rrNorm;
   logic [7:0]      r_age [NREQ];

   logic [NREQ-1:0] w_isHi, w_promo, w_hiReq, w_normReq;
   logic            w_found, w_winPromo, w_winHi, w_xfer;
   logic [IW-1:0]   w_win;
   logic [NREQ-1:0] w_winOh;

   // Returns {found, index}: first set bit of req scanning upward from ptr
   // with wrap-around at NREQ (NREQ need not be a power of two).
   function automatic logic [IW:0] rrPick(input logic [NREQ-1:0] req,
                                          input logic [IW-1:0]   ptr);
      logic          found;
      logic [IW-1:0] win;
      logic [IW:0]   pos;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
         if (!found && req[pos[IW-1:0]]) begin
            found = 1'b1;
            win   = pos[IW-1:0];
         end
      end
      return {found, win};
   endfunction

   function automatic logic [IW-1:0] nextPtr(input logic [IW-1:0] p);
      if (p == IW'(NREQ-1)) return '0;
      else                  return p + 1'b1;
   endfunction

   // Split valid requesters into the three priority tiers. A promoted
   // requester is taken out of its class tier so it is only seen once.
   always_comb begin
      w_isHi    = '0;
      w_promo   = '0;
      w_hiReq   = '0;
      w_normReq = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_isHi[i]    = iReqQoS[i*4+3];
         w_promo[i]   = iReqValid[i] & (r_age[i] == AGE_LIM);
         w_hiReq[i]   = iReqValid[i] & w_isHi[i] & ~w_promo[i];
         w_normReq[i] = iReqValid[i] & ~w_isHi[i] & ~w_promo[i];
      end
   end

   // Winner selection. While locked only the owner is considered, but it
   // still reports its tier so the correct pointer advances and a promoted
   // owner still raises oStarve.
   always_comb begin
      w_found    = 1'b0;
      w_win      = '0;
      w_winPromo = 1'b0;
      w_winHi    = 1'b0;
      if (r_state == ST_IDLE) begin
         if (|w_promo) begin
            {w_found, w_win} = rrPick(w_promo, r_rrNorm);
            w_winPromo       = 1'b1;
         end else if (|w_hiReq) begin
            {w_found, w_win} = rrPick(w_hiReq, r_rrHi);
            w_winHi          = 1'b1;
         end else begin
            {w_found, w_win} = rrPick(w_normReq, r_rrNorm);
         end
      end else begin
         w_found    = iReqValid[r_owner];
         w_win      = r_owner;
         w_winPromo = w_promo[r_owner];
         w_winHi    = w_hiReq[r_owner];
      end
   end

   // Accept is gated by the reset input so no requester sees a ready while
   // the block is held in reset.
   always_comb begin
      w_winOh        = '0;
      w_winOh[w_win] = 1'b1;
      w_xfer         = w_found & ~iFull & iWrResetn;
      oReqReady      = w_xfer ? w_winOh : '0;
   end

   // Lock FSM next state. The idle counter measures consecutive cycles with
   // the owner absent; it freezes together with the FSM while the wrapper is
   // full.
   always_comb begin
      w_stateNext    = r_state;
      w_ownerNext    = r_owner;
      w_lockIdleNext = r_lockIdle;
      case (r_state)
         ST_IDLE: begin
            w_lockIdleNext = '0;
            if (w_xfer && iReqLock[w_win]) begin
               w_stateNext = ST_LOCKED;
               w_ownerNext = w_win;
            end
         end
         ST_LOCKED: begin
            if (iReqValid[r_owner]) begin
               w_lockIdleNext = '0;
               if (w_xfer && !iReqLock[r_owner]) w_stateNext = ST_IDLE;
            end else if (!iFull) begin
               w_lockIdleNext = r_lockIdle + 8'd1;
               if (w_lockIdleNext >= AGE_LIM) begin
                  w_stateNext    = ST_IDLE;
                  w_lockIdleNext = '0;
               end
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // FSM, owner and lock-timeout registers.
   always_ff @(posedge iWrClk or negedge iWrResetn) begin
      if (!iWrResetn) begin
         r_state    <= ST_IDLE;
         r_owner    <= '0;
         r_lockIdle <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_owner    <= w_ownerNext;
         r_lockIdle <= w_lockIdleNext;
      end
   end

   // Round-robin pointers: promoted and normal grants share the normal
   // pointer, high-bandwidth grants move the high pointer.
   always_ff @(posedge iWrClk or negedge iWrResetn) begin
      if (!iWrResetn) begin
         r_rrHi   <= '0;
         r_rrNorm <= '0;
      end else if (w_xfer) begin
         if (w_winHi) r_rrHi   <= nextPtr(w_win);
         else         r_rrNorm <= nextPtr(w_win);
      end
   end

   // Age counters: count waiting cycles of valid normal-class requesters,
   // saturating at the promotion threshold. They keep counting during
   // backpressure and while another requester holds the lock.
   always_ff @(posedge iWrClk or negedge iWrResetn) begin
      if (!iWrResetn) begin
         for (int i = 0; i < NREQ; i++) r_age[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (!iReqValid[i] || w_isHi[i] || oReqReady[i]) r_age[i] <= '0;
            else if (r_age[i] != AGE_LIM)                   r_age[i] <= r_age[i] + 8'd1;
         end
      end
   end

   // Output beat register: loads on an accept, otherwise only the strobe and
   // starve pulse drop while data, QoS and grant hold their last values.
   always_ff @(posedge iWrClk or negedge iWrResetn) begin
      if (!iWrResetn) begin
         oWr     <= 1'b0;
         oWrData <= '0;
         oQoS    <= '0;
         oGrant  <= '0;
         oStarve <= 1'b0;
      end else if (w_xfer) begin
         oWr     <= 1'b1;
         oWrData <= iReqData[int'(w_win)*DSIZE +: DSIZE];
         oQoS    <= iReqQoS[int'(w_win)*4 +: 4];
         oGrant  <= w_winOh;
         oStarve <= w_winPromo;
      end else begin
         oWr     <= 1'b0;
         oStarve <= 1'b0;
      end
   end

endmodule

// File: tb/tb_qos_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qos_wr_arbiter
// Directed bench for qos_wr_arbiter (NREQ=4, DSIZE=32, AGE_MAX=15). Each step
// drives the requests, checks the combinational accept, pushes the beat the
// output register must show next cycle onto a queue, then pops and compares
// it after the clock edge.
// -----------------------------------------------------------------------------
module tb_qos_wr_arbiter;

   localparam int NREQ    = 4;
   localparam int DSIZE   = 32;
   localparam int AGE_MAX = 15;

   logic                  iWrClk = 1'b0;
   logic                  iWrResetn;
   logic [NREQ-1:0]       iReqValid;
   logic [NREQ*DSIZE-1:0] iReqData;
   logic [NREQ*4-1:0]     iReqQoS;
   logic [NREQ-1:0]       iReqLock;
   logic [NREQ-1:0]       oReqReady;
   logic                  iFull;
   logic                  oWr;
   logic [DSIZE-1:0]      oWrData;
   logic [3:0]            oQoS;
   logic [NREQ-1:0]       oGrant;
   logic                  oStarve;

   qos_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .AGE_MAX(AGE_MAX)) dut (
      .iWrClk(iWrClk), .iWrResetn(iWrResetn),
      .iReqValid(iReqValid), .iReqData(iReqData), .iReqQoS(iReqQoS),
      .iReqLock(iReqLock), .oReqReady(oReqReady), .iFull(iFull),
      .oWr(oWr), .oWrData(oWrData), .oQoS(oQoS), .oGrant(oGrant),
      .oStarve(oStarve)
   );

   always #5 iWrClk = ~iWrClk;

   typedef struct packed {
      logic             wr;
      logic [NREQ-1:0]  grant;
      logic [DSIZE-1:0] data;
      logic [3:0]       qos;
      logic             starve;
   } exp_t;

   exp_t             expQ[$];
   int               nCompared = 0;
   int               nFail     = 0;
   logic [DSIZE-1:0] reqData [NREQ];
   logic [3:0]       reqQos  [NREQ];
   logic [NREQ-1:0]  holdGrant;
   logic [DSIZE-1:0] holdData;
   logic [3:0]       holdQos;

   task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] lock,
                                input logic full);
      iReqValid = valid;
      iReqLock  = lock;
      iFull     = full;
      for (int i = 0; i < NREQ; i++) begin
         iReqData[i*DSIZE +: DSIZE] = reqData[i];
         iReqQoS[i*4 +: 4]          = reqQos[i];
      end
      #1;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         compare({tag, ".queue"}, 64'd0, 64'd1);
      end else begin
         e = expQ.pop_front();
         compare({tag, ".oWr"},     64'(oWr),     64'(e.wr));
         compare({tag, ".oGrant"},  64'(oGrant),  64'(e.grant));
         compare({tag, ".oWrData"}, 64'(oWrData), 64'(e.data));
         compare({tag, ".oQoS"},    64'(oQoS),    64'(e.qos));
         compare({tag, ".oStarve"}, 64'(oStarve), 64'(e.starve));
      end
   endtask

   // expWin < 0 means no requester may be accepted this cycle.
   task automatic stepCycle(input string tag, input int expWin, input logic expStarve);
      exp_t            e;
      logic [NREQ-1:0] oh;
      oh = '0;
      if (expWin >= 0) oh[expWin] = 1'b1;
      compare({tag, ".ready"}, 64'(oReqReady), 64'(oh));
      if (expWin >= 0) begin
         holdGrant = oh;
         holdData  = reqData[expWin];
         holdQos   = reqQos[expWin];
         e = '{wr: 1'b1, grant: oh, data: reqData[expWin], qos: reqQos[expWin], starve: expStarve};
      end else begin
         e = '{wr: 1'b0, grant: holdGrant, data: holdData, qos: holdQos, starve: 1'b0};
      end
      expQ.push_back(e);
      @(posedge iWrClk);
      #1;
      checkOutput(tag);
   endtask

   task automatic checkZero(input string tag);
      compare({tag, ".oWr"},       64'(oWr),       64'd0);
      compare({tag, ".oWrData"},   64'(oWrData),   64'd0);
      compare({tag, ".oQoS"},      64'(oQoS),      64'd0);
      compare({tag, ".oGrant"},    64'(oGrant),    64'd0);
      compare({tag, ".oStarve"},   64'(oStarve),   64'd0);
      compare({tag, ".oReqReady"}, 64'(oReqReady), 64'd0);
   endtask

   task automatic doReset();
      iWrResetn = 1'b0;
      applyStimulus('0, '0, 1'b0);
      expQ.delete();
      holdGrant = '0;
      holdData  = '0;
      holdQos   = '0;
      repeat (2) @(posedge iWrClk);
      @(negedge iWrClk);
      iWrResetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         reqData[i] = 32'h1111_1111 * (i + 1);
         reqQos[i]  = 4'h0;
      end
      reqQos[3]  = 4'h2;
      iWrResetn  = 1'b0;
      applyStimulus('0, '0, 1'b0);

      // Reset values, with requests present while reset is held.
      doReset();
      applyStimulus(4'b1111, '0, 1'b0);
      iWrResetn = 1'b0;
      #1;
      checkZero("reset");
      doReset();

      // Plain round robin across four normal requesters.
      applyStimulus(4'b1111, '0, 1'b0); stepCycle("rr0", 0, 1'b0);
      applyStimulus(4'b1111, '0, 1'b0); stepCycle("rr1", 1, 1'b0);
      applyStimulus(4'b1111, '0, 1'b0); stepCycle("rr2", 2, 1'b0);
      applyStimulus(4'b1111, '0, 1'b0); stepCycle("rr3", 3, 1'b0);
      applyStimulus(4'b1111, '0, 1'b0); stepCycle("rr4", 0, 1'b0);
      applyStimulus(4'b0000, '0, 1'b0); stepCycle("rrIdle", -1, 1'b0);

      // High-bandwidth requester 1 starves 0 and 2 until they are promoted.
      doReset();
      reqQos[1] = 4'h8;
      for (int c = 0; c < AGE_MAX; c++) begin
         applyStimulus(4'b0111, '0, 1'b0); stepCycle("hi", 1, 1'b0);
      end
      applyStimulus(4'b0111, '0, 1'b0); stepCycle("promo0", 0, 1'b1);
      applyStimulus(4'b0111, '0, 1'b0); stepCycle("promo2", 2, 1'b1);
      applyStimulus(4'b0111, '0, 1'b0); stepCycle("hiAgain", 1, 1'b0);
      reqQos[1] = 4'h0;

      // Lock burst by requester 2 while 3 waits.
      doReset();
      applyStimulus(4'b1100, 4'b0100, 1'b0); stepCycle("lock1", 2, 1'b0);
      applyStimulus(4'b1100, 4'b0100, 1'b0); stepCycle("lock2", 2, 1'b0);
      applyStimulus(4'b1100, 4'b0100, 1'b0); stepCycle("lock3", 2, 1'b0);
      applyStimulus(4'b1100, 4'b0000, 1'b0); stepCycle("lock4", 2, 1'b0);
      applyStimulus(4'b1100, 4'b0000, 1'b0); stepCycle("unlock3", 3, 1'b0);
      applyStimulus(4'b1100, 4'b0000, 1'b0); stepCycle("unlock2", 2, 1'b0);

      // Backpressure from the wrapper.
      doReset();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b0001, '0, 1'b1); stepCycle("full", -1, 1'b0);
      end
      applyStimulus(4'b0001, '0, 1'b0); stepCycle("fullRel", 0, 1'b0);
      applyStimulus(4'b0000, '0, 1'b0); stepCycle("fullIdle", -1, 1'b0);

      // Lock timeout: owner 0 disappears, 3 ages to promotion meanwhile.
      doReset();
      applyStimulus(4'b1001, 4'b0001, 1'b0); stepCycle("toLock", 0, 1'b0);
      for (int c = 0; c < AGE_MAX; c++) begin
         applyStimulus(4'b1000, '0, 1'b0); stepCycle("toWait", -1, 1'b0);
      end
      applyStimulus(4'b1000, '0, 1'b0); stepCycle("toGrant3", 3, 1'b1);

      // Reset while locked to requester 1.
      doReset();
      applyStimulus(4'b0010, 4'b0010, 1'b0); stepCycle("rlLock", 1, 1'b0);
      applyStimulus(4'b0011, 4'b0010, 1'b0); stepCycle("rlHold", 1, 1'b0);
      applyStimulus(4'b0011, 4'b0010, 1'b0);
      iWrResetn = 1'b0;
      #1;
      checkZero("rlReset");
      doReset();
      applyStimulus(4'b0011, 4'b0000, 1'b0); stepCycle("rlRestart0", 0, 1'b0);
      applyStimulus(4'b0011, 4'b0000, 1'b0); stepCycle("rlRestart1", 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
      $finish;
   end

endmodule
